// File: rtl/controlador_dma.sv
// controlador_dma: byte-wise DMA copier on the 8-bit data-memory port.
// Copies len bytes from src to dst, one read cycle then one write cycle per
// byte, always in increasing address order. Pointers and count wrap modulo
// 2^ADDR_W.
// Optional feature: define DMA_CHECKSUM_EN to add the chk output, a running
// XOR of every byte read since the last accepted start.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             request pulse, honoured only while idle
//   src, dst, len     block description, captured on an accepted start
//   abort             cancels a transfer in READ or WRITE
//   busy, done        busy during READ/WRITE, done pulses once in FIM
//   addr, memR, memW  memory address and read/write enables
//   DIN, DOUT         write data to memory, read data from memory
//   chk               running XOR of the bytes read (DMA_CHECKSUM_EN only)
module controlador_dma #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W-1:0] len,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    output logic              memR,
    output logic              memW,
    output logic [DATA_W-1:0] DIN,
    input  logic [DATA_W-1:0] DOUT
`ifdef DMA_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] chk
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_FIM   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_ptr_q, src_ptr_d;
    logic [ADDR_W-1:0] dst_ptr_q, dst_ptr_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] chk_q, chk_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_r_q, mem_r_d;
    logic              mem_w_q, mem_w_d;
    logic [DATA_W-1:0] din_q, din_d;

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            count_q   <= '0;
            buf_q     <= '0;
            chk_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            addr_q    <= '0;
            mem_r_q   <= 1'b0;
            mem_w_q   <= 1'b0;
            din_q     <= '0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            count_q   <= count_d;
            buf_q     <= buf_d;
            chk_q     <= chk_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            addr_q    <= addr_d;
            mem_r_q   <= mem_r_d;
            mem_w_q   <= mem_w_d;
            din_q     <= din_d;
        end
    end

    // Next state and datapath; outputs are decoded from the next state so the
    // registered outputs always match the state they belong to.
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        count_d   = count_q;
        buf_d     = buf_q;
        chk_d     = chk_q;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        addr_d    = '0;
        mem_r_d   = 1'b0;
        mem_w_d   = 1'b0;
        din_d     = '0;

        case (state_q)
            S_IDLE: begin
                // start outranks a simultaneous abort here
                if (start) begin
                    src_ptr_d = src;
                    dst_ptr_d = dst;
                    count_d   = len;
                    chk_d     = '0;
                    state_d   = (len != '0) ? S_READ : S_FIM;
                end
            end
            S_READ: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    buf_d     = DOUT;
                    chk_d     = chk_q ^ DOUT;
                    src_ptr_d = src_ptr_q + ADDR_W'(1);
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                // the falling-edge write of this cycle happens regardless of abort
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    dst_ptr_d = dst_ptr_q + ADDR_W'(1);
                    count_d   = count_q - ADDR_W'(1);
                    state_d   = (count_q != ADDR_W'(1)) ? S_READ : S_FIM;
                end
            end
            S_FIM: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        case (state_d)
            S_READ: begin
                busy_d  = 1'b1;
                addr_d  = src_ptr_d;
                mem_r_d = 1'b1;
            end
            S_WRITE: begin
                busy_d  = 1'b1;
                addr_d  = dst_ptr_d;
                mem_w_d = 1'b1;
                din_d   = buf_d;
            end
            S_FIM: begin
                done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign addr = addr_q;
    assign memR = mem_r_q;
    assign memW = mem_w_q;
    assign DIN  = din_q;

`ifdef DMA_CHECKSUM_EN
    assign chk = chk_q;
`else
    // Without the checksum feature the XOR register has no observer.
    logic unused_chk;
    assign unused_chk = ^chk_q;
`endif

endmodule
